// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Direct-mapped, write-through, no-write-allocate data-cache
//               controller. One 32-bit word per line, 2^INDEX_W lines.
//               Owns the tag and valid arrays; the data array is external
//               with an asynchronous read port.
//               Optional feature macro: DCACHE_CTRL_STATS_EN adds saturating
//               hit_cnt / miss_cnt outputs.
// Ports       : clk, rst_n                - clock, async active-low reset
//               cpu_rd/cpu_wr/cpu_addr/
//               cpu_wdata/cpu_rdata/stall - CPU load/store interface
//               arr_idx/arr_we/arr_wdata/
//               arr_rdata                 - external data array
//               mem_req/mem_we/mem_addr/
//               mem_wdata/mem_rdata/mem_ack - backing memory
//               hit_cnt/miss_cnt          - statistics (STATS build only)
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
    parameter int INDEX_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_rd,
    input  logic               cpu_wr,
    input  logic [31:0]        cpu_addr,
    input  logic [31:0]        cpu_wdata,
    output logic [31:0]        cpu_rdata,
    output logic               stall,
    output logic [INDEX_W-1:0] arr_idx,
    output logic               arr_we,
    output logic [31:0]        arr_wdata,
    input  logic [31:0]        arr_rdata,
    output logic               mem_req,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata,
    input  logic               mem_ack
`ifdef DCACHE_CTRL_STATS_EN
    ,
    output logic [15:0]        hit_cnt,
    output logic [15:0]        miss_cnt
`endif
);

    localparam int c_LINES = 1 << INDEX_W;
    localparam int c_TAG_W = 32 - INDEX_W - 3;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FILL  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [c_LINES-1:0] valid_q;
    logic [c_TAG_W-1:0] tag_q [c_LINES];
    logic [31:0]        rdata_q;

    logic [INDEX_W-1:0] w_idx;
    logic [c_TAG_W-1:0] w_tag;
    logic               w_hit;
    logic               w_is_wr;
    logic               w_is_rd;
    logic               w_fill_done;
    logic               w_unused_addr;

    assign w_idx   = cpu_addr[INDEX_W+2:3];
    assign w_tag   = cpu_addr[31:INDEX_W+3];
    assign w_hit   = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    // A simultaneous read and write request is serviced as a write.
    assign w_is_wr = cpu_wr;
    assign w_is_rd = cpu_rd & ~cpu_wr;
    assign w_fill_done = (state_q == c_FILL) && mem_ack;

    // Byte offset within the 8-byte line granule plays no part in lookup.
    assign w_unused_addr = ^cpu_addr[2:0];

    assign arr_idx   = w_idx;
    assign mem_addr  = {cpu_addr[31:3], 3'b000};
    assign mem_wdata = cpu_wdata;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (w_is_wr) begin
                    state_d = c_WRITE;
                end else if (w_is_rd && !w_hit) begin
                    state_d = c_FILL;
                end
            end
            c_FILL:  if (mem_ack) state_d = c_DONE;
            c_WRITE: if (mem_ack) state_d = c_DONE;
            c_DONE:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        stall     = 1'b0;
        arr_we    = 1'b0;
        arr_wdata = cpu_wdata;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        cpu_rdata = rdata_q;
        case (state_q)
            c_IDLE: begin
                if (w_is_wr) begin
                    // Write-through: update the array now on a hit, the
                    // memory write follows in WRITE. Misses leave the array.
                    stall  = 1'b1;
                    arr_we = w_hit;
                end else if (w_is_rd) begin
                    if (w_hit) begin
                        cpu_rdata = arr_rdata;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            c_FILL: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    arr_we    = 1'b1;
                    arr_wdata = mem_rdata;
                end
            end
            c_WRITE: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = 1'b1;
            end
            default: begin
                // DONE: one unstalled cycle presenting the captured data.
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Valid bits and captured fill data
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rdata_q <= '0;
        end else if (w_fill_done) begin
            valid_q[w_idx] <= 1'b1;
            rdata_q        <= mem_rdata;
        end
    end

    // Tags are only meaningful behind a set valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_fill_done) begin
            tag_q[w_idx] <= w_tag;
        end
    end

`ifdef DCACHE_CTRL_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    // One event per IDLE cycle carrying a request; that cycle either
    // completes (read hit) or leaves IDLE, so each access counts once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if ((state_q == c_IDLE) && (w_is_rd || w_is_wr)) begin
            if (w_hit) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Self-checking bench for dcache_ctrl. Models the external data
//               array and a backing memory that acks on the third request
//               cycle; expected load data goes through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dcache_ctrl;

    localparam int INDEX_W = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cpu_rd = 1'b0;
    logic               cpu_wr = 1'b0;
    logic [31:0]        cpu_addr = '0;
    logic [31:0]        cpu_wdata = '0;
    logic [31:0]        cpu_rdata;
    logic               stall;
    logic [INDEX_W-1:0] arr_idx;
    logic               arr_we;
    logic [31:0]        arr_wdata;
    logic [31:0]        arr_rdata;
    logic               mem_req;
    logic               mem_we;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata = '0;
    logic               mem_ack;
`ifdef DCACHE_CTRL_STATS_EN
    logic [15:0]        hit_cnt;
    logic [15:0]        miss_cnt;
`endif

    dcache_ctrl #(.INDEX_W(INDEX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .arr_idx   (arr_idx),
        .arr_we    (arr_we),
        .arr_wdata (arr_wdata),
        .arr_rdata (arr_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef DCACHE_CTRL_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // External data array (asynchronous read).
    logic [31:0] arr_mem [1 << INDEX_W];
    assign arr_rdata = arr_mem[arr_idx];
    always @(posedge clk) if (arr_we) arr_mem[arr_idx] <= arr_wdata;

    // Backing memory: word at line address A starts as {4{A[10:3]}}.
    logic [31:0] bmem [512];
    int          req_cnt;
    logic        ack_model;
    logic        ack_inj = 1'b0;
    assign mem_ack = ack_model | ack_inj;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_cnt   <= 0;
            ack_model <= 1'b0;
        end else begin
            ack_model <= 1'b0;
            if (mem_req && !mem_ack) begin
                if (req_cnt == 1) begin
                    ack_model <= 1'b1;
                    mem_rdata <= bmem[mem_addr[11:3]];
                    req_cnt   <= 0;
                end else begin
                    req_cnt <= req_cnt + 1;
                end
            end else begin
                req_cnt <= 0;
            end
            if (mem_req && mem_we && mem_ack) bmem[mem_addr[11:3]] <= mem_wdata;
        end
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];
    int          exp_hits = 0;
    int          exp_misses = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sat16(input int v);
        return (v > 65535) ? 32'h0000FFFF : 32'(v);
    endfunction

    // One CPU transaction; expectations derived from hit/miss and kind.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit exp_hit,
                       input logic [31:0] exp_data, input string tag);
        int          stalls = 0;
        int          arrwe = 0;
        int          memreq = 0;
        int          memwe = 0;
        logic        first_arrwe = 1'b0;
        logic [31:0] maddr = '0;
        logic [31:0] mwdata = '0;
        logic [31:0] got = '0;
        logic [31:0] exp;
        bit          done = 0;
        bit          is_wr = wr;

        @(posedge clk); #1;
        cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
        if (!is_wr) exp_q.push_back(exp_data);
        if (exp_hit) exp_hits++; else exp_misses++;

        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (i == 0) first_arrwe = arr_we;
            if (arr_we) arrwe++;
            if (mem_req) begin memreq++; maddr = mem_addr; end
            if (mem_req && mem_we) memwe++;
            if (mem_req && mem_we && mem_ack) mwdata = mem_wdata;
            if (stall) stalls++;
            else begin done = 1; got = cpu_rdata; end
        end
        @(posedge clk); #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0;

        chk({tag, "_complete"}, 32'(done), 32'd1);
        chk({tag, "_stall_cycles"}, 32'(stalls), (is_wr || !exp_hit) ? 32'd4 : 32'd0);
        chk({tag, "_arr_we_cycles"}, 32'(arrwe), is_wr ? 32'(exp_hit) : (exp_hit ? 32'd0 : 32'd1));
        chk({tag, "_mem_req_cycles"}, 32'(memreq), (is_wr || !exp_hit) ? 32'd3 : 32'd0);
        chk({tag, "_mem_we_cycles"}, 32'(memwe), is_wr ? 32'd3 : 32'd0);
        if (is_wr) begin
            chk({tag, "_arr_we_idle"}, 32'(first_arrwe), 32'(exp_hit));
            chk({tag, "_mem_wdata"}, mwdata, wdata);
        end
        if (is_wr || !exp_hit) chk({tag, "_mem_addr"}, maddr, {addr[31:3], 3'b000});
        if (!is_wr) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
            end else begin
                exp = exp_q.pop_front();
                chk({tag, "_rdata"}, got, exp);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << INDEX_W); i++) arr_mem[i] = '0;
        for (int i = 0; i < 512; i++) bmem[i] = {4{i[7:0]}};

        // Reset state
        #12;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_arr_we", 32'(arr_we), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        txn(1, 0, 32'h0000_0028, 32'h0,         0, 32'h0505_0505, "rd_miss_28");
        txn(1, 0, 32'h0000_002C, 32'h0,         1, 32'h0505_0505, "rd_hit_2c");
        txn(0, 1, 32'h0000_0028, 32'hAAAA_AAAA, 1, 32'h0,         "wr_hit_28");
        txn(1, 0, 32'h0000_0028, 32'h0,         1, 32'hAAAA_AAAA, "rd_hit_28");
        txn(0, 1, 32'h0000_0100, 32'h1234_5678, 0, 32'h0,         "wr_miss_100");
        txn(1, 0, 32'h0000_0100, 32'h0,         0, 32'h1234_5678, "rd_miss_100");
        txn(1, 1, 32'h0000_0028, 32'h5555_5555, 1, 32'h0,         "rdwr_28");
        txn(1, 0, 32'h0000_002C, 32'h0,         1, 32'h5555_5555, "rd_hit_2c_b");
        txn(1, 0, 32'h0000_0228, 32'h0,         0, 32'h4545_4545, "rd_conflict_228");
        txn(1, 0, 32'h0000_0028, 32'h0,         0, 32'h5555_5555, "rd_evicted_28");

`ifdef DCACHE_CTRL_STATS_EN
        chk("stats_hits", 32'(hit_cnt), sat16(exp_hits));
        chk("stats_misses", 32'(miss_cnt), sat16(exp_misses));
`endif

        // Reset in the middle of a fill, then a stray ack.
        @(posedge clk); #1;
        cpu_rd = 1'b1; cpu_addr = 32'h0000_0040;
        @(negedge clk);
        @(negedge clk);
        chk("fill_mem_req", 32'(mem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstfill_mem_req", 32'(mem_req), 32'd0);
        chk("rstfill_arr_we", 32'(arr_we), 32'd0);
        cpu_rd = 1'b0;
        #1;
        chk("rstfill_stall", 32'(stall), 32'd0);
        chk("rstfill_rdata", cpu_rdata, 32'd0);
        exp_hits = 0; exp_misses = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1 ack_inj = 1'b1;
        @(negedge clk);
        chk("late_ack_arr_we", 32'(arr_we), 32'd0);
        chk("late_ack_stall", 32'(stall), 32'd0);
        chk("late_ack_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1 ack_inj = 1'b0;

        txn(1, 0, 32'h0000_0040, 32'h0, 0, 32'h0808_0808, "rd_after_rst_40");
        txn(1, 0, 32'h0000_0028, 32'h0, 0, 32'h5555_5555, "rd_after_rst_28");

`ifdef DCACHE_CTRL_STATS_EN
        chk("stats_rst_hits", 32'(hit_cnt), sat16(exp_hits));
        chk("stats_rst_misses", 32'(miss_cnt), sat16(exp_misses));
        // 65537 back-to-back read hits saturate the hit counter.
        @(posedge clk); #1;
        cpu_rd = 1'b1; cpu_addr = 32'h0000_0040;
        for (int i = 0; i < 65537; i++) @(posedge clk);
        #1 cpu_rd = 1'b0;
        exp_hits += 65537;
        chk("stats_sat_hits", 32'(hit_cnt), sat16(exp_hits));
        chk("stats_sat_misses", 32'(miss_cnt), sat16(exp_misses));
`endif

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter INDEX_W, default 4, meaning line-index width (2^INDEX_W lines, one 32-bit word per line).
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cpu_rd  input  1  load request (MemRead).
REQ-005 cpu_wr  input  1  store request (MemWrite).
REQ-006 cpu_addr  input  32  byte address (ALU result).
REQ-007 cpu_wdata  input  32  store data.
REQ-008 cpu_rdata  output  32  load data.
REQ-009 stall  output  1  CPU must hold request and operands stable while high.
REQ-010 arr_idx  output  INDEX_W  data-array line select.
REQ-011 arr_we  output  1  data-array write enable.
REQ-012 arr_wdata  output  32  data-array write data.
REQ-013 arr_rdata  input  32  data-array asynchronous read data.
REQ-014 mem_req / mem_we  output  1 each  backing-memory request / write qualifier.
REQ-015 mem_addr  output  32  memory address, bits [2:0] always zero.
REQ-016 mem_wdata  output  32; mem_rdata  input  32; mem_ack  input  1  one-cycle completion pulse.

Function
REQ-017 index = cpu_addr[INDEX_W+2:3]; tag = cpu_addr[31:INDEX_W+3]; controller SHALL own the tag and valid arrays.
REQ-018 States: IDLE, FILL, WRITE, DONE.
REQ-019 hit = valid[index] && tag match, evaluated combinationally in IDLE; arr_idx = index in all states.
REQ-020 IDLE read hit: stall 0, cpu_rdata = arr_rdata same cycle, state stays IDLE.
REQ-021 IDLE read miss: stall 1 same cycle, next state FILL.
REQ-022 FILL: mem_req 1, mem_we 0, mem_addr = {cpu_addr[31:3],3'b000}; on mem_ack: arr_we 1, arr_wdata = mem_rdata, tag written, valid set, mem_rdata captured into cpu_rdata register, next DONE.
REQ-023 IDLE write (hit or miss): stall 1, next WRITE; on hit, arr_we 1 with arr_wdata = cpu_wdata that cycle (write-through); on miss, array/tags untouched (no write-allocate).
REQ-024 WRITE: mem_req 1, mem_we 1, mem_wdata = cpu_wdata; on mem_ack next DONE.
REQ-025 DONE: stall 0 for exactly one cycle, cpu_rdata = captured value, requests ignored, next IDLE.
REQ-026 mem_req SHALL stay high until the mem_ack cycle and drop the following cycle; mem_ack outside FILL/WRITE SHALL be ignored.
REQ-027 cpu_rd and cpu_wr both high SHALL be treated as a write.
REQ-028 No request in IDLE: stall 0, mem_req 0, arr_we 0.
REQ-029 arr_we SHALL never be high in WRITE or DONE.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, all valid bits 0, mem_req 0, mem_we 0, arr_we 0, cpu_rdata register 0, counters 0.
REQ-031 Reset mid-FILL/WRITE SHALL abandon the transaction without array update; a later mem_ack is ignored.
REQ-032 Tag array contents need no reset.

Configuration
REQ-033 With DCACHE_CTRL_STATS_EN defined: outputs hit_cnt[15:0] and miss_cnt[15:0]; hit_cnt +1 per IDLE read or write hit, miss_cnt +1 per IDLE read or write miss; both saturate at 16'hFFFF.
REQ-034 Without DCACHE_CTRL_STATS_EN: ports and counters absent; all other behaviour identical.

Verification
REQ-035 After reset, read 0x00000028, mem_ack after 3 cycles with mem_rdata 0x05050505 -> mem_addr 0x00000028, stall 4 cycles, DONE cpu_rdata 0x05050505.
REQ-036 Re-read 0x0000002C -> same line hit, stall 0, cpu_rdata 0x05050505 same cycle, mem_req stays 0.
REQ-037 Write 0x00000028 data 0xAAAAAAAA -> arr_we pulse at IDLE, mem_we 1 until ack; subsequent read hit returns 0xAAAAAAAA.
REQ-038 Write miss 0x00000100 -> mem write issued, arr_we never high; following read of 0x00000100 misses.
REQ-039 rst_n low during FILL, then late mem_ack -> mem_req drops immediately, no arr_we, re-read of same address misses.
REQ-040 STATS build: 65537 read hits -> hit_cnt 16'hFFFF.
